// File: rtl/lsu_pkg.sv
// Shared LSU definitions: load queue entry layout, sizing constants and the
// load issue FSM state encoding.
package lsu_pkg;

    localparam int XLEN          = 32;
    localparam int ROB_TAG_WIDTH = 6;
    localparam int LDQ_SIZE      = 16;
    localparam int STQ_SIZE      = 8;

    typedef struct packed {
        logic                     valid;
        logic                     address_valid;
        logic                     executed;
        logic                     order_fail;
        logic [XLEN-1:0]          address;
        logic [ROB_TAG_WIDTH-1:0] rob_tag;
    } load_queue_entry;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } issue_state_t;

endpackage

// File: rtl/load_issue_unit_if.sv
// Data memory request/response channel between the load issue unit (master)
// and the data cache (slave).
interface load_issue_unit_if;
    import lsu_pkg::*;

    logic                     mem_req_valid;
    logic                     mem_req_ready;
    logic [XLEN-1:0]          mem_req_addr;
    logic [ROB_TAG_WIDTH-1:0] mem_req_rob_tag;
    logic                     mem_resp_valid;
    logic [XLEN-1:0]          mem_resp_data;
    logic [ROB_TAG_WIDTH-1:0] mem_resp_rob_tag;

    modport master (
        output mem_req_valid, mem_req_addr, mem_req_rob_tag,
        input  mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_rob_tag
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, mem_req_rob_tag,
        output mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_rob_tag
    );

endinterface

// File: rtl/load_response_fifo.sv
// Circular response buffer with no bypass; head output reads zero while empty
// so nothing stale reaches the CDB.
module load_response_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == FULL_COUNT);
    assign empty     = (count_r == {(PTR_W + 1){1'b0}});
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign head_data = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W + 1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (PTR_W + 1)'(1);
                2'b01:   count_r <= count_r - (PTR_W + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    load_response_fifo_chk u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: rtl/load_response_fifo_chk.sv
// Protocol checker for load_response_fifo: no push when full, no pop when empty.
module load_response_fifo_chk (
    input logic clk,
    input logic rst_n,
    input logic push,
    input logic pop,
    input logic full,
    input logic empty
);

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full))
        else $error("load_response_fifo: push while full");

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty))
        else $error("load_response_fifo: pop while empty");

endmodule

// File: rtl/load_issue_unit.sv
// Picks the oldest ready load from the LDQ, issues it to data memory, and
// buffers responses for broadcast on the CDB.
module load_issue_unit
    import lsu_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  load_queue_entry              load_queue_entries [LDQ_SIZE],
    input  logic [$clog2(LDQ_SIZE)-1:0]  head,
    load_issue_unit_if.master            mem,
    output logic                         load_executed,
    output logic [ROB_TAG_WIDTH-1:0]     load_executed_rob_tag,
    output logic                         load_succeeded,
    output logic [ROB_TAG_WIDTH-1:0]     load_succeeded_rob_tag,
    output logic                         cdb_valid,
    output logic [XLEN-1:0]              cdb_data,
    output logic [ROB_TAG_WIDTH-1:0]     cdb_rob_tag,
    input  logic                         cdb_ready
);

    localparam int IDX_W = $clog2(LDQ_SIZE);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CNT_W-1:0] CAP = CNT_W'(MAX_OUTSTANDING);

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // First eligible entry walking from start with wrap-around
    function automatic pick_t pick_oldest(input load_queue_entry entries [LDQ_SIZE],
                                          input logic [IDX_W-1:0] start);
        pick_t            pick;
        logic [IDX_W-1:0] idx;
        load_queue_entry  e;
        pick.found = 1'b0;
        pick.idx   = {IDX_W{1'b0}};
        for (int i = 0; i < LDQ_SIZE; i++) begin
            idx = start + IDX_W'(i);
            e   = entries[idx];
            if (!pick.found && e.valid && e.address_valid && !e.executed && !e.order_fail) begin
                pick.found = 1'b1;
                pick.idx   = idx;
            end
        end
        return pick;
    endfunction

    issue_state_t             state_r;
    issue_state_t             state_nxt_s;
    pick_t                    pick_s;
    logic                     latch_s;
    logic                     handshake_s;
    logic [XLEN-1:0]          req_addr_r;
    logic [ROB_TAG_WIDTH-1:0] req_tag_r;
    logic [CNT_W-1:0]         outstanding_r;
    logic                     pop_s;
    logic                     dec_s;
    logic                     fifo_full_s;
    logic                     fifo_empty_s;
    logic [XLEN+ROB_TAG_WIDTH-1:0] fifo_head_s;

    assign pick_s = pick_oldest(load_queue_entries, head);

    // Next-state and handshake decode for the issue FSM
    always_comb begin
        state_nxt_s = state_r;
        latch_s     = 1'b0;
        handshake_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (pick_s.found && (outstanding_r < CAP)) begin
                    latch_s     = 1'b1;
                    state_nxt_s = REQ;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REQ: begin
                if (mem.mem_req_ready) begin
                    handshake_s = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = REQ;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM state and request fields, held stable while in REQ
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            req_addr_r <= {XLEN{1'b0}};
            req_tag_r  <= {ROB_TAG_WIDTH{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (latch_s) begin
                req_addr_r <= load_queue_entries[pick_s.idx].address;
                req_tag_r  <= load_queue_entries[pick_s.idx].rob_tag;
            end
        end
    end

    // A pop with no recorded issue (e.g. a pre-reset response) must not underflow
    assign pop_s = cdb_valid && cdb_ready;
    assign dec_s = pop_s && (outstanding_r != {CNT_W{1'b0}});

    // Loads issued but not yet broadcast on the CDB
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outstanding_r <= {CNT_W{1'b0}};
        end else begin
            case ({handshake_s, dec_s})
                2'b10:   outstanding_r <= outstanding_r + CNT_W'(1);
                2'b01:   outstanding_r <= outstanding_r - CNT_W'(1);
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    assign mem.mem_req_valid   = (state_r == REQ);
    assign mem.mem_req_addr    = req_addr_r;
    assign mem.mem_req_rob_tag = req_tag_r;

    assign load_executed          = handshake_s;
    assign load_executed_rob_tag  = handshake_s ? req_tag_r : {ROB_TAG_WIDTH{1'b0}};
    assign load_succeeded         = mem.mem_resp_valid && reset;
    assign load_succeeded_rob_tag = load_succeeded ? mem.mem_resp_rob_tag : {ROB_TAG_WIDTH{1'b0}};

    load_response_fifo #(
        .WIDTH (XLEN + ROB_TAG_WIDTH),
        .DEPTH (MAX_OUTSTANDING)
    ) u_resp_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (mem.mem_resp_valid),
        .push_data ({mem.mem_resp_data, mem.mem_resp_rob_tag}),
        .pop       (pop_s),
        .head_data (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    assign cdb_valid   = !fifo_empty_s;
    assign cdb_data    = fifo_head_s[XLEN+ROB_TAG_WIDTH-1:ROB_TAG_WIDTH];
    assign cdb_rob_tag = fifo_head_s[ROB_TAG_WIDTH-1:0];

endmodule

// File: tb/tb_load_issue_unit.sv
// Directed bench for load_issue_unit: acts as LDQ and data memory, checks
// issue order, backpressure, outstanding cap, response buffering and reset.
module tb_load_issue_unit;
    import lsu_pkg::*;

    logic                     clk;
    logic                     reset;
    load_queue_entry          ldq [LDQ_SIZE];
    logic [$clog2(LDQ_SIZE)-1:0] head;
    logic                     load_executed;
    logic [ROB_TAG_WIDTH-1:0] load_executed_rob_tag;
    logic                     load_succeeded;
    logic [ROB_TAG_WIDTH-1:0] load_succeeded_rob_tag;
    logic                     cdb_valid;
    logic [XLEN-1:0]          cdb_data;
    logic [ROB_TAG_WIDTH-1:0] cdb_rob_tag;
    logic                     cdb_ready;

    int n_checks = 0;
    int n_fail   = 0;
    logic [ROB_TAG_WIDTH-1:0] issued_q [$];
    logic [ROB_TAG_WIDTH-1:0] resp_q [$];

    load_issue_unit_if mem_bus ();

    load_issue_unit #(.MAX_OUTSTANDING(4)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .load_queue_entries     (ldq),
        .head                   (head),
        .mem                    (mem_bus.master),
        .load_executed          (load_executed),
        .load_executed_rob_tag  (load_executed_rob_tag),
        .load_succeeded         (load_succeeded),
        .load_succeeded_rob_tag (load_succeeded_rob_tag),
        .cdb_valid              (cdb_valid),
        .cdb_data               (cdb_data),
        .cdb_rob_tag            (cdb_rob_tag),
        .cdb_ready              (cdb_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, observed, expected);
        end
    endtask

    function automatic logic [XLEN-1:0] resp_word(input logic [ROB_TAG_WIDTH-1:0] tag);
        return 32'hC0DE_0000 | {26'd0, tag};
    endfunction

    task automatic clear_ldq();
        for (int i = 0; i < LDQ_SIZE; i++) ldq[i] = '0;
    endtask

    task automatic set_entry(input int idx, input logic [XLEN-1:0] addr, input logic [ROB_TAG_WIDTH-1:0] tag);
        ldq[idx].valid         = 1'b1;
        ldq[idx].address_valid = 1'b1;
        ldq[idx].executed      = 1'b0;
        ldq[idx].order_fail    = 1'b0;
        ldq[idx].address       = addr;
        ldq[idx].rob_tag       = tag;
    endtask

    // One clock: record an executed pulse, then mark the LDQ like the real queue would
    task automatic tick();
        logic                     ex;
        logic [ROB_TAG_WIDTH-1:0] ex_tag;
        logic                     done;
        ex     = load_executed;
        ex_tag = load_executed_rob_tag;
        @(posedge clk);
        #1;
        if (ex) begin
            issued_q.push_back(ex_tag);
            done = 1'b0;
            for (int i = 0; i < LDQ_SIZE; i++) begin
                if (!done && ldq[i].valid && !ldq[i].executed && ldq[i].rob_tag == ex_tag) begin
                    ldq[i].executed = 1'b1;
                    done = 1'b1;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Return responses for resp_q in order with the CDB stalled, then pop them all
    task automatic drain();
        cdb_ready = 1'b0;
        foreach (resp_q[k]) begin
            mem_bus.mem_resp_valid   = 1'b1;
            mem_bus.mem_resp_rob_tag = resp_q[k];
            mem_bus.mem_resp_data    = resp_word(resp_q[k]);
            #1;
            chk("drain_succ_tag", 64'(load_succeeded_rob_tag), 64'(resp_q[k]));
            tick();
        end
        mem_bus.mem_resp_valid = 1'b0;
        cdb_ready = 1'b1;
        #1;
        foreach (resp_q[k]) begin
            chk("drain_cdb_valid", 64'(cdb_valid), 64'd1);
            chk("drain_cdb_tag", 64'(cdb_rob_tag), 64'(resp_q[k]));
            chk("drain_cdb_data", 64'(cdb_data), 64'(resp_word(resp_q[k])));
            tick();
            #1;
        end
        chk("drain_cdb_empty", 64'(cdb_valid), 64'd0);
        resp_q.delete();
    endtask

    initial begin
        reset = 1'b0;
        head  = '0;
        cdb_ready = 1'b1;
        clear_ldq();
        mem_bus.mem_req_ready    = 1'b1;
        mem_bus.mem_resp_valid   = 1'b1;
        mem_bus.mem_resp_data    = 32'h1234_5678;
        mem_bus.mem_resp_rob_tag = 6'd3;
        @(negedge clk);
        #1;
        chk("rst_req_valid", 64'(mem_bus.mem_req_valid), 64'd0);
        chk("rst_succeeded", 64'(load_succeeded), 64'd0);
        chk("rst_succ_tag", 64'(load_succeeded_rob_tag), 64'd0);
        chk("rst_cdb_valid", 64'(cdb_valid), 64'd0);
        chk("rst_cdb_data", 64'(cdb_data), 64'd0);
        tick();
        reset = 1'b1;
        mem_bus.mem_resp_valid = 1'b0;
        tick();

        // Single load
        set_entry(0, 32'h100, 6'd5);
        #1;
        chk("single_c0_valid", 64'(mem_bus.mem_req_valid), 64'd0);
        tick();
        chk("single_c1_valid", 64'(mem_bus.mem_req_valid), 64'd1);
        chk("single_c1_addr", 64'(mem_bus.mem_req_addr), 64'h100);
        chk("single_c1_tag", 64'(mem_bus.mem_req_rob_tag), 64'd5);
        chk("single_c1_exec", 64'(load_executed), 64'd1);
        chk("single_c1_exec_tag", 64'(load_executed_rob_tag), 64'd5);
        tick();
        chk("single_c2_valid", 64'(mem_bus.mem_req_valid), 64'd0);
        tick();
        mem_bus.mem_resp_valid   = 1'b1;
        mem_bus.mem_resp_data    = 32'hDEAD_BEEF;
        mem_bus.mem_resp_rob_tag = 6'd5;
        #1;
        chk("single_c3_succ", 64'(load_succeeded), 64'd1);
        chk("single_c3_succ_tag", 64'(load_succeeded_rob_tag), 64'd5);
        chk("single_c3_cdb_valid", 64'(cdb_valid), 64'd0);
        tick();
        mem_bus.mem_resp_valid = 1'b0;
        #1;
        chk("single_c4_cdb_valid", 64'(cdb_valid), 64'd1);
        chk("single_c4_cdb_data", 64'(cdb_data), 64'hDEAD_BEEF);
        chk("single_c4_cdb_tag", 64'(cdb_rob_tag), 64'd5);
        tick();
        chk("single_c5_cdb_valid", 64'(cdb_valid), 64'd0);

        // Oldest-first with wrap, out-of-order responses
        clear_ldq();
        issued_q.delete();
        head = 4'd14;
        set_entry(1, 32'h0110, 6'd12);
        set_entry(15, 32'h1500, 6'd11);
        set_entry(14, 32'h1400, 6'd10);
        ticks(10);
        chk("wrap_count", 64'(issued_q.size()), 64'd3);
        if (issued_q.size() == 3) begin
            chk("wrap_first", 64'(issued_q[0]), 64'd10);
            chk("wrap_second", 64'(issued_q[1]), 64'd11);
            chk("wrap_third", 64'(issued_q[2]), 64'd12);
        end
        resp_q = '{6'd12, 6'd10, 6'd11};
        drain();

        // Backpressure
        clear_ldq();
        issued_q.delete();
        head = 4'd0;
        mem_bus.mem_req_ready = 1'b0;
        set_entry(2, 32'h200, 6'd20);
        #1;
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", 64'(mem_bus.mem_req_valid), 64'd1);
            chk("bp_addr", 64'(mem_bus.mem_req_addr), 64'h200);
            chk("bp_tag", 64'(mem_bus.mem_req_rob_tag), 64'd20);
            chk("bp_no_exec", 64'(load_executed), 64'd0);
            tick();
        end
        mem_bus.mem_req_ready = 1'b1;
        #1;
        chk("bp_exec", 64'(load_executed), 64'd1);
        chk("bp_exec_tag", 64'(load_executed_rob_tag), 64'd20);
        tick();
        chk("bp_after_valid", 64'(mem_bus.mem_req_valid), 64'd0);
        ticks(3);
        chk("bp_one_pulse", 64'(issued_q.size()), 64'd1);
        resp_q = '{6'd20};
        drain();

        // Outstanding cap
        clear_ldq();
        issued_q.delete();
        cdb_ready = 1'b0;
        for (int i = 0; i < 6; i++) set_entry(i, 32'h3000 + 32'(i * 4), 6'(30 + i));
        #1;
        ticks(14);
        chk("cap_count", 64'(issued_q.size()), 64'd4);
        chk("cap_idle", 64'(mem_bus.mem_req_valid), 64'd0);
        mem_bus.mem_resp_valid   = 1'b1;
        mem_bus.mem_resp_rob_tag = 6'd30;
        mem_bus.mem_resp_data    = resp_word(6'd30);
        #1;
        tick();
        mem_bus.mem_resp_valid = 1'b0;
        cdb_ready = 1'b1;
        #1;
        chk("cap_pop_tag", 64'(cdb_rob_tag), 64'd30);
        tick();
        cdb_ready = 1'b0;
        ticks(8);
        chk("cap_fifth_count", 64'(issued_q.size()), 64'd5);
        if (issued_q.size() == 5) chk("cap_fifth_tag", 64'(issued_q[4]), 64'd34);
        resp_q = '{6'd31, 6'd32, 6'd33, 6'd34};
        drain();
        ticks(4);
        chk("cap_sixth_count", 64'(issued_q.size()), 64'd6);
        if (issued_q.size() == 6) chk("cap_sixth_tag", 64'(issued_q[5]), 64'd35);
        resp_q = '{6'd35};
        drain();

        // Ineligible entries skipped
        clear_ldq();
        issued_q.delete();
        set_entry(0, 32'h400, 6'd40);
        ldq[0].order_fail = 1'b1;
        set_entry(1, 32'h404, 6'd41);
        ldq[1].executed = 1'b1;
        set_entry(2, 32'h408, 6'd42);
        ldq[2].address_valid = 1'b0;
        set_entry(3, 32'h40C, 6'd43);
        #1;
        ticks(8);
        chk("skip_count", 64'(issued_q.size()), 64'd1);
        if (issued_q.size() == 1) chk("skip_tag", 64'(issued_q[0]), 64'd43);
        resp_q = '{6'd43};
        drain();

        // Reset mid-REQ with two buffered responses
        clear_ldq();
        issued_q.delete();
        cdb_ready = 1'b0;
        set_entry(4, 32'h500, 6'd50);
        set_entry(5, 32'h504, 6'd51);
        #1;
        ticks(6);
        chk("rmid_issued", 64'(issued_q.size()), 64'd2);
        for (int k = 0; k < 2; k++) begin
            mem_bus.mem_resp_valid   = 1'b1;
            mem_bus.mem_resp_rob_tag = 6'(50 + k);
            mem_bus.mem_resp_data    = resp_word(6'(50 + k));
            #1;
            tick();
        end
        mem_bus.mem_resp_valid = 1'b0;
        mem_bus.mem_req_ready  = 1'b0;
        set_entry(6, 32'h508, 6'd52);
        #1;
        tick();
        chk("rmid_in_req", 64'(mem_bus.mem_req_valid), 64'd1);
        chk("rmid_fifo_busy", 64'(cdb_valid), 64'd1);
        reset = 1'b0;
        mem_bus.mem_req_ready    = 1'b1;
        mem_bus.mem_resp_valid   = 1'b1;
        mem_bus.mem_resp_rob_tag = 6'd9;
        cdb_ready = 1'b1;
        #1;
        chk("rmid_req_valid", 64'(mem_bus.mem_req_valid), 64'd0);
        chk("rmid_req_addr", 64'(mem_bus.mem_req_addr), 64'd0);
        chk("rmid_req_tag", 64'(mem_bus.mem_req_rob_tag), 64'd0);
        chk("rmid_exec", 64'(load_executed), 64'd0);
        chk("rmid_exec_tag", 64'(load_executed_rob_tag), 64'd0);
        chk("rmid_succ", 64'(load_succeeded), 64'd0);
        chk("rmid_cdb_valid", 64'(cdb_valid), 64'd0);
        chk("rmid_cdb_data", 64'(cdb_data), 64'd0);
        chk("rmid_cdb_tag", 64'(cdb_rob_tag), 64'd0);
        tick();
        reset = 1'b1;
        mem_bus.mem_resp_valid = 1'b0;
        cdb_ready = 1'b0;
        clear_ldq();
        issued_q.delete();
        #1;
        chk("rpost_cdb_valid", 64'(cdb_valid), 64'd0);
        chk("rpost_req_valid", 64'(mem_bus.mem_req_valid), 64'd0);
        for (int i = 0; i < 5; i++) set_entry(i, 32'h600 + 32'(i * 4), 6'(55 + i));
        #1;
        ticks(14);
        chk("rpost_cap_count", 64'(issued_q.size()), 64'd4);
        resp_q = '{6'd55, 6'd56, 6'd57, 6'd58};
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_issue_unit.md
# load_issue_unit

Consumer side of the load queue: scans LDQ entries from head, picks the oldest load with a resolved address that has not yet fired, and issues it to the data memory over a valid/ready request channel. It generates the `load_executed` and `load_succeeded` pulses the load queue consumes, buffers memory responses, and presents them to the CDB with their ROB tags. It sits in the LSU between `load_queue` and the data cache.

## Interface
- `XLEN`, `ROB_TAG_WIDTH`, `LDQ_SIZE`, `STQ_SIZE`: no module parameters; taken from `lsu_pkg`.
- `MAX_OUTSTANDING`, default 4: maximum number of loads issued but not yet popped by the CDB. Power of two, at least 2.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low.
- `load_queue_entries` input `load_queue_entry [LDQ_SIZE]`: LDQ state.
- `head` input `$clog2(LDQ_SIZE)`: LDQ head, the oldest entry.
- `mem_req_valid` output 1: request present.
- `mem_req_ready` input 1: memory accepts the request.
- `mem_req_addr` output XLEN: load address.
- `mem_req_rob_tag` output ROB_TAG_WIDTH: tag carried with the request.
- `mem_resp_valid` input 1: response present. Always accepted.
- `mem_resp_data` input XLEN: loaded word.
- `mem_resp_rob_tag` input ROB_TAG_WIDTH: tag of the response.
- `load_executed` output 1, `load_executed_rob_tag` output ROB_TAG_WIDTH: pulse to the LDQ.
- `load_succeeded` output 1, `load_succeeded_rob_tag` output ROB_TAG_WIDTH: pulse to the LDQ.
- `cdb_valid` output 1, `cdb_data` output XLEN, `cdb_rob_tag` output ROB_TAG_WIDTH: broadcast request.
- `cdb_ready` input 1: CDB grant.

## Operation
- Candidate: an entry with `valid && address_valid && !executed && !order_fail`. Search order is `head, head+1, …` modulo LDQ_SIZE. The first hit wins.
- Issue FSM has two states.
  - **IDLE**: `mem_req_valid=0`. If a candidate exists and `outstanding < MAX_OUTSTANDING`, latch the candidate's address and rob_tag into the request register and go to REQ.
  - **REQ**: `mem_req_valid=1` with the latched fields held stable. When `mem_req_ready` is 1, the handshake completes, `load_executed=1` with the latched tag in the same cycle, `outstanding` increments, and the FSM returns to IDLE. Otherwise it stays in REQ.
  - A request is never withdrawn once `mem_req_valid` is asserted.
- Responses:
  - `load_succeeded = mem_resp_valid` combinationally, with `load_succeeded_rob_tag = mem_resp_rob_tag`.
  - `{data, tag}` is pushed into the response FIFO (depth MAX_OUTSTANDING) on the same edge.
  - The FIFO cannot overflow because of the outstanding cap. A push to a full FIFO is an assertion failure.
- CDB:
  - The FIFO head drives `cdb_valid/cdb_data/cdb_rob_tag`.
  - The entry is popped on `cdb_valid && cdb_ready`, and `outstanding` decrements.
  - Increment and decrement in the same cycle leave `outstanding` unchanged.
- Returned data is the raw word. Byte/half extraction and sign extension happen downstream.
- Responses may return out of order. The FIFO preserves arrival order.

## Timing
- Reset values:
  - FSM = IDLE, `outstanding = 0`, FIFO empty.
  - All outputs are 0: `mem_req_valid`, `mem_req_addr`, `mem_req_rob_tag`, `load_executed`, `load_succeeded`, both `*_rob_tag` outputs, `cdb_valid`, `cdb_data`, `cdb_rob_tag`.
- Issue latency:
  - A candidate visible in cycle N gives `mem_req_valid` in cycle N+1.
  - With the handshake in N+1, `load_executed` pulses in N+1. The LDQ sets `executed` at the end of N+1, and IDLE reselects in N+2.
  - Peak rate is one issue per 2 cycles. The 2-cycle spacing guarantees the just-fired entry is never reselected.
- Response to CDB: a response in cycle M pushes at the end of M. `cdb_valid` rises in M+1. There is no FIFO bypass.
- FIFO pointers wrap modulo MAX_OUTSTANDING. The count is `$clog2(MAX_OUTSTANDING)+1` bits wide.
- The LDQ search index wraps modulo LDQ_SIZE. An empty or all-ineligible LDQ keeps the FSM in IDLE.
- Reset asserted mid-REQ or with the FIFO non-empty immediately clears all state. In-flight responses arriving after reset deassertion are still pushed. The memory side is reset together with this block.

## Structure
- `lsu_pkg` owns `load_queue_entry`, XLEN, ROB_TAG_WIDTH, LDQ_SIZE and STQ_SIZE.
- Add an `issue_state_t` enum (IDLE, REQ) to `lsu_pkg`.
- The response buffer is a sub-module `load_response_fifo` (parameterized by width and depth, push/pop/full/empty). The oldest-first wrap-around select is a function inside this module.

## Test plan
- **Single load.** Setup: entry 0 valid, addr_valid, addr 0x100, tag 5; ready=1. Required: `mem_req_valid` in cycle 1 with addr 0x100, tag 5, and `load_executed` tag 5 in cycle 1. A response in cycle 3 with data 0xDEADBEEF gives `load_succeeded` tag 5 in cycle 3 and `cdb_valid` with 0xDEADBEEF, tag 5 in cycle 4.
- **Oldest-first with wrap.** Setup: head=14; entries 14, 15, 1 eligible. Required: issue order is tags of 14, 15, 1.
- **Backpressure.** Setup: `mem_req_ready=0` for 5 cycles. Required: `mem_req_valid` and addr/tag stay stable, with no `load_executed`, until ready; exactly one pulse then follows.
- **Outstanding cap.** Setup: MAX=4, `cdb_ready=0`, 6 eligible loads. Required: exactly 4 handshakes. After one CDB pop, the 5th issues.
- **Ineligible entries skipped.** Setup: an entry with `order_fail=1`, and an entry with `executed=1`. Required: never issued.
- **Reset mid-operation.** Setup: assert reset during REQ with the FIFO holding 2 entries. Required: all outputs 0 in the same cycle; after release, `cdb_valid=0`, `outstanding=0`.
